// File: rtl/ser_frame8.sv
// Frame serializer: start bit, 8 data bits, optional even parity, stop bit,
// each held CLKS_PER_BIT cycles on a registered, idle-high line.
module ser_frame8 #(
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       load,
  output logic       ready,
  output logic       ser_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] word_q, word_d;
  logic       ser_q, ser_d;
  logic       done_q, done_d;
  logic       bit_end;

  function automatic logic pick_bit(input logic [7:0] w, input logic [2:0] i);
    if (MSB_FIRST != 0) return w[3'd7 - i];
    else                return w[i];
  endfunction

  assign bit_end = (cnt_q == CNT_LAST);

  // ser_d is the value the line carries in the state being entered, so the
  // output stays a plain register with no combinational path to the pin.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    word_d  = word_q;
    ser_d   = ser_q;
    done_d  = 1'b0;

    if (state_q != IDLE) cnt_d = bit_end ? 8'd0 : cnt_q + 8'd1;

    unique case (state_q)
      IDLE: begin
        ser_d = 1'b1;
        if (load) begin
          state_d = START;
          word_d  = data;
          cnt_d   = 8'd0;
          idx_d   = 3'd0;
          ser_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = 3'd0;
          ser_d   = pick_bit(word_q, 3'd0);
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              ser_d   = ^word_q;
            end else begin
              state_d = STOP;
              ser_d   = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            ser_d = pick_bit(word_q, idx_q + 3'd1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          ser_d   = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          ser_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ser_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      word_q  <= 8'd0;
      ser_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign ser_out = ser_q;
  assign done    = done_q;

endmodule

// File: tb/tb_ser_frame8.sv
// Bench for ser_frame8: three parameterisations checked every cycle against a
// bit-queue frame model, plus directed literal frame sequences.
module tb_ser_frame8;

  logic       clk;
  logic       rst_v   [3];
  logic       load_v  [3];
  logic [7:0] data_v  [3];
  logic       ser_v   [3];
  logic       busy_v  [3];
  logic       ready_v [3];
  logic       done_v  [3];

  int n_tests = 0;
  int n_fail  = 0;

  ser_frame8 u0 (
    .clk(clk), .rst(rst_v[0]), .data(data_v[0]), .load(load_v[0]),
    .ready(ready_v[0]), .ser_out(ser_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );
  ser_frame8 #(.CLKS_PER_BIT(3)) u1 (
    .clk(clk), .rst(rst_v[1]), .data(data_v[1]), .load(load_v[1]),
    .ready(ready_v[1]), .ser_out(ser_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );
  ser_frame8 #(.MSB_FIRST(1), .PARITY_EN(0)) u2 (
    .clk(clk), .rst(rst_v[2]), .data(data_v[2]), .load(load_v[2]),
    .ready(ready_v[2]), .ser_out(ser_v[2]), .busy(busy_v[2]), .done(done_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int cpb_of(input int k);
    return (k == 1) ? 3 : 1;
  endfunction
  function automatic bit par_of(input int k);
    return (k != 2);
  endfunction
  function automatic bit msb_of(input int k);
    return (k == 2);
  endfunction

  bit   mq [3][$];
  logic m_ser [3];
  logic m_busy[3];
  logic m_done[3];
  bit   m_fin [3];
  bit   mvalid = 1'b0;

  task automatic push_frame(input int k, input logic [7:0] w);
    bit b;
    for (int c = 0; c < cpb_of(k); c++) mq[k].push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      b = msb_of(k) ? w[7-i] : w[i];
      for (int c = 0; c < cpb_of(k); c++) mq[k].push_back(b);
    end
    if (par_of(k))
      for (int c = 0; c < cpb_of(k); c++) mq[k].push_back(^w);
    for (int c = 0; c < cpb_of(k); c++) mq[k].push_back(1'b1);
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_v[k]) begin
        mq[k].delete();
        m_ser[k]  <= 1'b1;
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b0;
        m_fin[k]  <= 1'b0;
      end else if (mq[k].size() != 0) begin
        m_ser[k]  <= mq[k].pop_front();
        m_busy[k] <= 1'b1;
        m_done[k] <= 1'b0;
        if (mq[k].size() == 0) m_fin[k] <= 1'b1;
      end else if (m_fin[k]) begin
        m_ser[k]  <= 1'b1;
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b1;
        m_fin[k]  <= 1'b0;
      end else begin
        m_done[k] <= 1'b0;
        if (load_v[k]) begin
          push_frame(k, data_v[k]);
          m_ser[k]  <= mq[k].pop_front();
          m_busy[k] <= 1'b1;
        end else begin
          m_ser[k]  <= 1'b1;
          m_busy[k] <= 1'b0;
        end
      end
    end
    mvalid <= 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("model_ser[%0d]", k),   int'(ser_v[k]),   int'(m_ser[k]));
        check($sformatf("model_busy[%0d]", k),  int'(busy_v[k]),  int'(m_busy[k]));
        check($sformatf("model_ready[%0d]", k), int'(ready_v[k]), int'(!m_busy[k]));
        check($sformatf("model_done[%0d]", k),  int'(done_v[k]),  int'(m_done[k]));
      end
    end
  end

  int done_cnt0 = 0;
  always @(negedge clk) if (done_v[0]) done_cnt0 <= done_cnt0 + 1;

  // ---------------- directed stimulus ----------------
  task automatic start_frame(input int k, input logic [7:0] w);
    @(posedge clk); #1;
    data_v[k] = w;
    load_v[k] = 1'b1;
    @(posedge clk); #1;
    load_v[k] = 1'b0;
    data_v[k] = ~w;
  endtask

  task automatic record(input int k, input int n, output logic [15:0] r);
    r = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      r = {r[14:0], ser_v[k]};
    end
  endtask

  initial begin
    logic [15:0] rec;
    int base, bc, done_at, s4, s7, s28;

    for (int k = 0; k < 3; k++) begin
      rst_v[k]  = 1'b1;
      load_v[k] = 1'b1;
      data_v[k] = 8'hA5;
    end

    // Reset held with load asserted
    for (int e = 0; e < 2; e++) begin
      @(negedge clk);
      check("rst_ser",   int'(ser_v[0]),   1);
      check("rst_busy",  int'(busy_v[0]),  0);
      check("rst_ready", int'(ready_v[0]), 1);
      check("rst_done",  int'(done_v[0]),  0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      rst_v[k]  = 1'b0;
      load_v[k] = 1'b0;
    end
    repeat (2) @(posedge clk);

    // Default frame of 8'h1E
    base = done_cnt0;
    start_frame(0, 8'h1E);
    record(0, 11, rec);
    check("frame_1E", int'(rec), int'(16'b00000_00111100001));
    @(negedge clk);
    check("1E_done", int'(done_v[0]), 1);
    @(negedge clk);
    check("1E_ready", int'(ready_v[0]), 1);
    check("1E_done_once", done_cnt0 - base, 1);

    // Load during DATA bit 2 is ignored
    base = done_cnt0;
    start_frame(0, 8'h0F);
    fork
      record(0, 11, rec);
      begin
        repeat (3) @(posedge clk); #1;
        data_v[0] = 8'hFF;
        load_v[0] = 1'b1;
        @(posedge clk); #1;
        load_v[0] = 1'b0;
      end
    join
    check("frame_0F", int'(rec), int'(16'b00000_01111000001));
    repeat (4) @(posedge clk);
    check("0F_one_done", done_cnt0 - base, 1);

    // Reset mid-frame, then a clean frame
    start_frame(0, 8'hA5);
    repeat (4) @(posedge clk); #1;
    rst_v[0] = 1'b1;
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    base = done_cnt0;
    @(negedge clk);
    check("abort_ser",  int'(ser_v[0]),  1);
    check("abort_busy", int'(busy_v[0]), 0);
    repeat (4) @(posedge clk);
    check("abort_no_done", done_cnt0 - base, 0);
    start_frame(0, 8'h3C);
    record(0, 11, rec);
    check("frame_3C", int'(rec), int'(16'b00000_00011110001));
    repeat (3) @(posedge clk);

    // CLKS_PER_BIT=3 with 8'h01
    start_frame(1, 8'h01);
    bc = 0; done_at = 0; s4 = -1; s7 = -1; s28 = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (busy_v[1]) bc++;
      if (i == 4)  s4  = int'(ser_v[1]);
      if (i == 7)  s7  = int'(ser_v[1]);
      if (i == 28) s28 = int'(ser_v[1]);
      if (done_v[1]) begin
        done_at = i;
        break;
      end
    end
    check("cpb3_busy_cycles", bc, 33);
    check("cpb3_done_cycle",  done_at, 34);
    check("cpb3_bit0",   s4,  1);
    check("cpb3_bit1",   s7,  0);
    check("cpb3_parity", s28, 1);

    // MSB first, no parity, back-to-back load in the done cycle
    start_frame(2, 8'h80);
    record(2, 10, rec);
    check("frame_80_msb", int'(rec), int'(16'b000000_0100000001));
    @(negedge clk);
    check("b2b_done", int'(done_v[2]), 1);
    check("b2b_idle_ser", int'(ser_v[2]), 1);
    data_v[2] = 8'h80;
    load_v[2] = 1'b1;
    @(posedge clk); #1;
    load_v[2] = 1'b0;
    @(negedge clk);
    check("b2b_start_ser",  int'(ser_v[2]),  0);
    check("b2b_start_busy", int'(busy_v[2]), 1);
    repeat (14) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
